tetris_ctrl: RTL
================

Name: tetris_ctrl

Overview:
Game-control FSM directly upstream of the datapath. It sequences the state code the datapath consumes (NEWBOARD, GEN, MOVE, LAND, CLEAR, GAMEOVER) and turns raw button levels into single-cycle move codes. It paces gravity with a tick counter. It also holds the architectural registers (board, piece, location, rotation) that feed the datapath and are updated from the datapath's outputs.

Parameters:
DROP_TICKS, 16, number of MOVE-state cycles between gravity steps (minimum 2).
CNT_W, 8, width of the gravity counter and of pieces_placed.

Ports:
clka  input  1  system clock, all state updates on rising edge
restart  input  1  synchronous active-high reset
btn_left  input  1  left button level
btn_right  input  1  right button level
btn_rotate  input  1  rotate button level
piece_in  input  2  piece type produced by the datapath
location_in  input  5  new location from the datapath
rotation_in  input  2  new rotation from the datapath
board_in  input  32  board produced by the datapath
touched  input  1  datapath reports that the piece has landed
error_in  input  1  datapath redraw error
state  output  3  GEN=0, MOVE=1, LAND=2, CLEAR=3, NEWBOARD=4, GAMEOVER=5
move  output  2  0=none/gravity, 1=left, 2=right, 3=rotate
step  output  1  datapath update cycle strobe
curr_piece  output  2  registered current piece
location  output  5  registered piece location
rotation  output  2  registered piece rotation
board  output  32  registered board; bit index = row*4+col, row 0 = top, 4 cols x 8 rows
game_over  output  1  high while in GAMEOVER
pieces_placed  output  CNT_W  count of landed pieces, saturating

Behaviour:
- Clock and reset: one clock, clka; reset restart is synchronous and active-high.
- restart (any state, any cycle) gives the following register values:
  - state=NEWBOARD; board, curr_piece, location, rotation = 0.
  - pieces_placed=0; gravity counter=0; pending=0; button history=0.
  - step=0, move=0, game_over=0.
- Button edges:
  - Each button is registered once.
  - A rising edge is a current level of 1 with a previous level of 0.
  - Edges are accepted only in MOVE while pending==0.
  - Simultaneous edges: priority rotate > right > left; losing edges are dropped.
  - Edges arriving while pending!=0 are dropped.
- move and step are decoded combinationally from the current registers (0-cycle latency). Registered outputs change only on a clock edge.
- NEWBOARD: 1 cycle, board<=0, then GEN.
- GEN: 1 cycle.
  - curr_piece<=piece_in; rotation<=0.
  - location<=1 if piece_in<2, else 5.
  - Gravity counter<=0. Next state MOVE.
- MOVE, action step: if pending!=0, then step=1 and move=pending in that cycle. At the clock edge:
  - location<=location_in, rotation<=rotation_in, board<=board_in.
  - pending<=0.
- MOVE, gravity step:
  - The counter increments on every MOVE cycle with no step.
  - At DROP_TICKS-1 with pending==0: step=1, move=0, same captures as an action step, counter<=0.
  - If pending!=0 when the counter reaches terminal, the action step wins and the counter holds at terminal. The gravity step occurs on the next non-action cycle.
- MOVE exit: touched is sampled only in step cycles. touched=1 in a step cycle means the step's captures occur and next state is LAND. touched outside a step cycle is ignored.
- LAND: 1 cycle.
  - board<=board_in.
  - pieces_placed increments and saturates at all-ones.
  - pending<=0. Next state CLEAR.
- CLEAR: 1 cycle, board<=board_in.
  - If board_in[3:0]!=0 or error_in=1: next state GAMEOVER.
  - Otherwise: next state GEN.
- GAMEOVER:
  - game_over=1; board<=32'hFFFFFFFF.
  - All buttons ignored; step=0.
  - Exits only through restart.
- step=0 and move=0 in every state except MOVE step cycles.
- Reserved state codes 6 and 7 go to NEWBOARD on the next cycle.

Test Plan:
- Reset, then idle: cycle 0 NEWBOARD with board=0 → GEN with piece_in=2 gives location=5, rotation=0 → MOVE. With DROP_TICKS=16, the first gravity step (step=1, move=0) occurs on the 16th MOVE cycle.
- Press btn_left for 3 cycles in MOVE: exactly one step with move=1, one cycle after the edge. Location captures location_in=4; no further steps until the next edge or gravity.
- btn_rotate and btn_right rise together: a single step with move=3. A right edge while pending is set is dropped.
- Action pending when the gravity counter hits terminal: action step first, gravity step on the following cycle; counter then restarts at 0.
- touched=1 in a gravity step: MOVE→LAND→CLEAR→GEN, pieces_placed 0→1. With board_in[3:0]=4'b0010 in CLEAR: →GAMEOVER, board=FFFFFFFF, game_over=1. Buttons cause no step. restart returns to NEWBOARD with pieces_placed=0.
- restart asserted mid-MOVE with pending=2: next cycle state=NEWBOARD, move=0, step=0, and no stale move is issued after GEN.

Source files
------------

// File: rtl/tetris_ctrl.sv
// -----------------------------------------------------------------------------
// tetris_ctrl
//
// Game-control sequencer sitting directly upstream of the tetris datapath.
// It produces the state code the datapath decodes, converts raw button
// levels into single-cycle move codes, paces gravity with a tick counter and
// holds the architectural registers (board, piece, location, rotation) that
// the datapath reads and then rewrites through its *_in outputs.
//
// Parameters
//   DROP_TICKS    MOVE-state cycles between gravity steps (>= 2)
//   CNT_W         width of the gravity counter and of pieces_placed
//
// Ports
//   clka          system clock, every register updates on the rising edge
//   restart       synchronous active-high reset
//   btn_left      left button level
//   btn_right     right button level
//   btn_rotate    rotate button level
//   piece_in      piece type offered by the datapath (taken in GEN)
//   location_in   next location computed by the datapath
//   rotation_in   next rotation computed by the datapath
//   board_in      next board computed by the datapath
//   touched       datapath reports the piece has landed (valid on step only)
//   error_in      datapath redraw error (examined in CLEAR)
//   state         GEN=0 MOVE=1 LAND=2 CLEAR=3 NEWBOARD=4 GAMEOVER=5
//   move          0=none/gravity 1=left 2=right 3=rotate
//   step          datapath update strobe
//   curr_piece    registered current piece
//   location      registered piece location
//   rotation      registered piece rotation
//   board         registered board, bit = row*4+col, row 0 at the top
//   game_over     high while in GAMEOVER
//   pieces_placed saturating count of landed pieces
// -----------------------------------------------------------------------------
module tetris_ctrl #(
  parameter int DROP_TICKS = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clka,
  input  logic             restart,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_rotate,
  input  logic [1:0]       piece_in,
  input  logic [4:0]       location_in,
  input  logic [1:0]       rotation_in,
  input  logic [31:0]      board_in,
  input  logic             touched,
  input  logic             error_in,
  output logic [2:0]       state,
  output logic [1:0]       move,
  output logic             step,
  output logic [1:0]       curr_piece,
  output logic [4:0]       location,
  output logic [1:0]       rotation,
  output logic [31:0]      board,
  output logic             game_over,
  output logic [CNT_W-1:0] pieces_placed
);

  // State codes are fixed by the datapath's decoder.
  localparam logic [2:0] ST_GEN      = 3'd0;
  localparam logic [2:0] ST_MOVE     = 3'd1;
  localparam logic [2:0] ST_LAND     = 3'd2;
  localparam logic [2:0] ST_CLEAR    = 3'd3;
  localparam logic [2:0] ST_NEWBOARD = 3'd4;
  localparam logic [2:0] ST_GAMEOVER = 3'd5;

  localparam logic [1:0] MV_NONE   = 2'd0;
  localparam logic [1:0] MV_LEFT   = 2'd1;
  localparam logic [1:0] MV_RIGHT  = 2'd2;
  localparam logic [1:0] MV_ROTATE = 2'd3;

  // Counter value on which a gravity step is issued.
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DROP_TICKS - 1);
  localparam logic [CNT_W-1:0] TICK_ONE  = CNT_W'(1);

  // Spawn columns: narrow pieces (types 0,1) start further left.
  localparam logic [4:0] LOC_SPAWN_NARROW = 5'd1;
  localparam logic [4:0] LOC_SPAWN_WIDE   = 5'd5;

  logic [CNT_W-1:0] tick_cnt;
  logic [1:0]       pending;     // accepted move waiting for its step cycle
  logic             btn_left_q;
  logic             btn_right_q;
  logic             btn_rotate_q;

  logic             in_move;
  logic             action_step;
  logic             gravity_step;
  logic [1:0]       edge_code;

  // ---------------------------------------------------------------------------
  // Output decode: purely from registers, so move/step are valid for the
  // whole cycle and never depend on the raw button inputs.
  // ---------------------------------------------------------------------------
  assign in_move      = (state == ST_MOVE);
  assign action_step  = in_move && (pending != MV_NONE);
  // A pending action steals the terminal tick; gravity then fires on the
  // next cycle because the counter holds at TICK_LAST.
  assign gravity_step = in_move && (pending == MV_NONE) && (tick_cnt == TICK_LAST);

  assign step      = action_step || gravity_step;
  assign move      = action_step ? pending : MV_NONE;
  assign game_over = (state == ST_GAMEOVER);

  // ---------------------------------------------------------------------------
  // Button rising edges with rotate > right > left priority. Losing edges are
  // simply not encoded, which drops them.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    edge_code = MV_NONE;
    if (btn_rotate && !btn_rotate_q)
      edge_code = MV_ROTATE;
    else if (btn_right && !btn_right_q)
      edge_code = MV_RIGHT;
    else if (btn_left && !btn_left_q)
      edge_code = MV_LEFT;
  end

  // ---------------------------------------------------------------------------
  // Sequencer and architectural registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clka) begin
    if (restart) begin
      state         <= ST_NEWBOARD;
      board         <= '0;
      curr_piece    <= '0;
      location      <= '0;
      rotation      <= '0;
      pieces_placed <= '0;
      tick_cnt      <= '0;
      pending       <= MV_NONE;
      btn_left_q    <= 1'b0;
      btn_right_q   <= 1'b0;
      btn_rotate_q  <= 1'b0;
    end else begin
      // Button history tracks the levels in every state so that a button
      // held across a state change does not produce a late edge.
      btn_left_q   <= btn_left;
      btn_right_q  <= btn_right;
      btn_rotate_q <= btn_rotate;

      case (state)
        ST_NEWBOARD: begin
          board <= '0;
          state <= ST_GEN;
        end

        ST_GEN: begin
          curr_piece <= piece_in;
          rotation   <= 2'd0;
          location   <= (piece_in < 2'd2) ? LOC_SPAWN_NARROW : LOC_SPAWN_WIDE;
          tick_cnt   <= '0;
          state      <= ST_MOVE;
        end

        ST_MOVE: begin
          if (step) begin
            // Action and gravity steps capture the datapath result alike.
            location <= location_in;
            rotation <= rotation_in;
            board    <= board_in;
            pending  <= MV_NONE;
            if (gravity_step)
              tick_cnt <= '0;
            // touched is only meaningful alongside a step.
            if (touched)
              state <= ST_LAND;
          end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
          end

          // A new edge is accepted only while nothing is queued; it may
          // arrive during a gravity step, which leaves pending clear.
          if ((pending == MV_NONE) && (edge_code != MV_NONE))
            pending <= edge_code;
        end

        ST_LAND: begin
          board   <= board_in;
          pending <= MV_NONE;
          if (pieces_placed != '1)
            pieces_placed <= pieces_placed + TICK_ONE;
          state   <= ST_CLEAR;
        end

        ST_CLEAR: begin
          board <= board_in;
          // Anything left in the top row, or a redraw fault, ends the game.
          if ((board_in[3:0] != 4'd0) || error_in)
            state <= ST_GAMEOVER;
          else
            state <= ST_GEN;
        end

        ST_GAMEOVER: begin
          board <= 32'hFFFF_FFFF;
        end

        default: begin
          state <= ST_NEWBOARD;
        end
      endcase
    end
  end

endmodule
